// File: rtl/van_der_pol_simple.sv
// van_der_pol_simple: forward-Euler Q16.16 solver for x' = u, u' = mu(1-x^2)u - x.
// Four cycles per step; each new (t, x, u) is flagged by a one-cycle valid, then done sticks.
module van_der_pol_simple #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_init,
    input  logic [WIDTH-1:0] u_init,
    input  logic [WIDTH-1:0] dt,
    input  logic [WIDTH-1:0] mu,
    input  logic [WIDTH-1:0] t_max,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] u_out,
    output logic [WIDTH-1:0] t_out,
    output logic             done,
    output logic             valid
);
    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, UPDATE, DONE} state_t;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;
    state_t           state_q;
    logic [WIDTH-1:0] x_q, u_q, t_q, dt_q, mu_q, tmax_q, x2_q, dx_q, damp_q, f_q;
    logic [WIDTH-1:0] x_d, u_d, t_d;
    logic             valid_q, done_q, stop_d;
    function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
        return WIDTH'(p >>> FRAC_BITS);
    endfunction
    // next state is built only from pre-step values
    assign x_d    = x_q + dx_q;
    assign u_d    = u_q + mul(f_q, dt_q);
    assign t_d    = t_q + dt_q;
    assign stop_d = $signed(t_d) >= $signed(tmax_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            u_q     <= '0;
            t_q     <= '0;
            dt_q    <= '0;
            mu_q    <= '0;
            tmax_q  <= '0;
            x2_q    <= '0;
            dx_q    <= '0;
            damp_q  <= '0;
            f_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start) begin
                    x_q     <= x_init;
                    u_q     <= u_init;
                    t_q     <= '0;
                    dt_q    <= dt;
                    mu_q    <= mu;
                    tmax_q  <= t_max;
                    done_q  <= 1'b0;
                    state_q <= MUL1;
                end
                MUL1: begin
                    x2_q    <= mul(x_q, x_q);
                    dx_q    <= mul(u_q, dt_q);
                    state_q <= MUL2;
                end
                MUL2: begin
                    damp_q  <= mul(mu_q, ONE - x2_q);
                    state_q <= MUL3;
                end
                MUL3: begin
                    f_q     <= mul(damp_q, u_q) - x_q;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    x_q     <= x_d;
                    u_q     <= u_d;
                    t_q     <= t_d;
                    valid_q <= 1'b1;
                    done_q  <= stop_d;
                    state_q <= stop_d ? DONE : MUL1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign x_out = x_q;
    assign u_out = u_q;
    assign t_out = t_q;
    assign valid = valid_q;
    assign done  = done_q;
endmodule

// File: tb/tb_van_der_pol_simple.sv
// tb_van_der_pol_simple: scoreboard bench for van_der_pol_simple.
// Expected steps come from a longint reference model queued at each start.
module tb_van_der_pol_simple;
    logic        clk = 1'b0;
    logic        rst, start, done, valid;
    logic [31:0] x_init, u_init, dt, mu, t_max, x_out, u_out, t_out;

    typedef struct {int x; int u; int t; bit last;} step_t;
    step_t sb[$];
    step_t last_exp;
    int    cmp_cnt = 0, err_cnt = 0;
    int    n_valid, s1x, s1u, s1t, s2x, s2u, s2t, lt;

    van_der_pol_simple #(.WIDTH(32), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_init(x_init), .u_init(u_init), .dt(dt), .mu(mu), .t_max(t_max),
        .x_out(x_out), .u_out(u_out), .t_out(t_out), .done(done), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mulq(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 16);
    endfunction

    task automatic push_model(input int xi, input int ui, input int dti, input int mui, input int tmi);
        int  x, u, t, x2, dx, damp, f;
        bit  last;
        x = xi; u = ui; t = 0;
        do begin
            x2   = mulq(x, x);
            dx   = mulq(u, dti);
            damp = mulq(mui, 65536 - x2);
            f    = mulq(damp, u) - x;
            u    = u + mulq(f, dti);
            x    = x + dx;
            t    = t + dti;
            last = (t >= tmi);
            sb.push_back('{x, u, t, last});
        end while (!last);
    endtask

    task automatic run(input int xi, input int ui, input int dti, input int mui, input int tmi,
                       input int pulse_at, input int budget);
        int    gap, seen;
        step_t e;
        @(negedge clk);
        x_init = xi; u_init = ui; dt = dti; mu = mui; t_max = tmi; start = 1'b1;
        push_model(xi, ui, dti, mui, tmi);
        @(negedge clk);
        start = 1'b0; x_init = 0; u_init = 0; dt = 1; mu = 0; t_max = 32'h7fffffff;
        chk("done_clear", int'(done), 0);
        gap = 0; seen = 0;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            @(negedge clk);
            gap++;
            if (start) start = 1'b0;
            if (valid) begin
                e = sb.pop_front();
                seen++;
                chk("step_gap", gap, 4);
                chk("x_out", int'(x_out), e.x);
                chk("u_out", int'(u_out), e.u);
                chk("t_out", int'(t_out), e.t);
                chk("done_with_valid", int'(done), int'(e.last));
                if (seen == 1) begin s1x = int'(x_out); s1u = int'(u_out); s1t = int'(t_out); end
                if (seen == 2) begin s2x = int'(x_out); s2u = int'(u_out); s2t = int'(t_out); end
                lt = int'(t_out);
                last_exp = e;
                gap = 0;
                if (seen == pulse_at) start = 1'b1;
            end
        end
        chk("steps_pending", sb.size(), 0);
        sb.delete();
        n_valid = seen;
    endtask

    task automatic check_frozen();
        repeat (8) begin
            @(negedge clk);
            chk("hold_valid", int'(valid), 0);
            chk("hold_done", int'(done), 1);
            chk("hold_x", int'(x_out), last_exp.x);
            chk("hold_u", int'(u_out), last_exp.u);
            chk("hold_t", int'(t_out), last_exp.t);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        x_init = 0; u_init = 0; dt = 0; mu = 0; t_max = 0;
        repeat (2) @(negedge clk);
        chk("rst_x", int'(x_out), 0);
        chk("rst_u", int'(u_out), 0);
        chk("rst_t", int'(t_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_valid", int'(valid), 0);
            chk("idle_done", int'(done), 0);
        end

        run(65536, 0, 6553, 65536, 655360, 0, 600);
        chk("nom_count", n_valid, 101);
        chk("nom_s1x", s1x, 65536);
        chk("nom_s1u", s1u, -6553);
        chk("nom_s1t", s1t, 6553);
        chk("nom_s2x", s2x, 64880);
        chk("nom_s2u", s2u, -13106);
        chk("nom_s2t", s2t, 13106);
        chk("nom_last_t", lt, 661853);
        check_frozen();

        run(65536, 0, 6553, 65536, 655360, 2, 600);
        chk("busy_count", n_valid, 101);
        chk("busy_s2x", s2x, 64880);
        chk("busy_last_t", lt, 661853);
        check_frozen();

        run(131072, 0, 6553, 65536, 19659, 0, 100);
        chk("re_count", n_valid, 3);
        chk("re_s1x", s1x, 131072);
        chk("re_s1u", s1u, -13106);
        chk("re_s1t", s1t, 6553);
        check_frozen();

        run(65536, 0, 6553, 65536, 0, 0, 50);
        chk("tmax0_count", n_valid, 1);
        chk("tmax0_t", s1t, 6553);
        check_frozen();

        @(negedge clk);
        x_init = 65536; u_init = 0; dt = 6553; mu = 65536; t_max = 655360; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_x", int'(x_out), 0);
        chk("arst_u", int'(u_out), 0);
        chk("arst_t", int'(t_out), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_valid", int'(valid), 0);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_t", int'(t_out), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
